// File: rtl/jogador_automatico.sv
// Automatic memory-game player: records the LED sequence shown by the game,
// then replays it on the buttons with fixed press/release timing.
module jogador_automatico #(
  parameter int MAX_JOGADAS = 16,
  parameter int T_SILENCIO  = 8,
  parameter int T_PRESS     = 4,
  parameter int T_GAP       = 4,
  localparam int CW         = $clog2(MAX_JOGADAS) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          habilitar,
  input  logic [3:0]    leds,
  input  logic          errar_en,
  input  logic [CW-1:0] errar_idx,
  output logic [3:0]    botoes,
  output logic          ocupado,
  output logic          fim_jogada,
  output logic          erro_leds,
  output logic          estouro,
  output logic [2:0]    db_estado,
  output logic [CW-1:0] db_contagem
);
  localparam int AW = (MAX_JOGADAS > 1) ? $clog2(MAX_JOGADAS) : 1;
  localparam int SW = $clog2(T_SILENCIO + 1);
  localparam int TW = $clog2(T_PRESS + T_GAP + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_JOGADAS);
  localparam logic [SW-1:0] SIL_MAX = SW'(T_SILENCIO);
  localparam logic [TW-1:0] PRESS_M1 = TW'(T_PRESS - 1);
  localparam logic [TW-1:0] GAP_M1   = TW'(T_GAP - 1);

  typedef enum logic [2:0] {
    INICIAL   = 3'd0,
    CAPTURA   = 3'd1,
    PRESSIONA = 3'd2,
    SOLTA     = 3'd3,
    FIM       = 3'd4
  } estado_t;

  estado_t       estado, estado_n;
  logic [3:0]    mem [MAX_JOGADAS];
  logic [3:0]    leds_prev;
  logic [CW-1:0] count, idx, idx_n;
  logic [SW-1:0] sil;
  logic [TW-1:0] tmr;
  logic [3:0]    botoes_n, entrada;
  logic          onehot, cap_ev, cap_ok;

  assign onehot = (leds != 4'd0) && ((leds & (leds - 4'd1)) == 4'd0);
  assign cap_ev = (estado == CAPTURA) && onehot && (leds_prev == 4'd0);
  assign cap_ok = cap_ev && (count != CNT_MAX);

  assign ocupado     = (estado == PRESSIONA) || (estado == SOLTA);
  assign fim_jogada  = (estado == FIM);
  assign db_estado   = estado;
  assign db_contagem = count;

  always_comb begin
    estado_n = estado;
    idx_n    = idx;
    botoes_n = 4'd0;
    entrada  = 4'd0;
    if (!habilitar) begin
      estado_n = INICIAL;
    end else begin
      case (estado)
        INICIAL:   estado_n = CAPTURA;
        CAPTURA:   if (sil == SIL_MAX) begin
                     estado_n = PRESSIONA;
                     idx_n    = '0;
                   end
        PRESSIONA: if (tmr == PRESS_M1) estado_n = SOLTA;
        SOLTA:     if (tmr == GAP_M1) begin
                     if ((idx + CW'(1)) < count) begin
                       estado_n = PRESSIONA;
                       idx_n    = idx + CW'(1);
                     end else begin
                       estado_n = FIM;
                     end
                   end
        FIM:       estado_n = CAPTURA;
        default:   estado_n = INICIAL;
      endcase
    end
    // botoes is registered, so it is loaded with the value of the state being entered
    if (estado_n == PRESSIONA) begin
      entrada  = mem[idx_n[AW-1:0]];
      botoes_n = (errar_en && (idx_n == errar_idx)) ? {entrada[2:0], entrada[3]} : entrada;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= INICIAL;
      idx       <= '0;
      botoes    <= 4'd0;
      leds_prev <= 4'd0;
      tmr       <= '0;
      count     <= '0;
      sil       <= '0;
      erro_leds <= 1'b0;
      estouro   <= 1'b0;
    end else begin
      estado    <= estado_n;
      idx       <= idx_n;
      botoes    <= botoes_n;
      leds_prev <= leds;
      tmr <= (ocupado && (estado_n == estado)) ? tmr + TW'(1) : '0;
      case (estado)
        INICIAL, FIM: begin
          count <= '0;
          sil   <= '0;
        end
        CAPTURA: begin
          if (cap_ev) begin
            if (count == CNT_MAX) estouro <= 1'b1;
            else                  count   <= count + CW'(1);
          end
          if ((leds != 4'd0) && !onehot) erro_leds <= 1'b1;
          // silence only counts once something has been captured
          if (leds != 4'd0)                          sil <= '0;
          else if ((count != '0) && (sil != SIL_MAX)) sil <= sil + SW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (cap_ok) mem[count[AW-1:0]] <= leds;
  end
endmodule

// File: tb/tb_jogador_automatico.sv
// Directed bench for jogador_automatico: table of capture/replay rounds plus
// hand-written overflow, silence-wait and abort sequences.
module tb_jogador_automatico;
  localparam int CW = 5;

  logic          clock = 1'b0;
  logic          reset, habilitar, errar_en;
  logic [3:0]    leds;
  logic [CW-1:0] errar_idx;
  logic [3:0]    botoes;
  logic          ocupado, fim_jogada, erro_leds, estouro;
  logic [2:0]    db_estado;
  logic [CW-1:0] db_contagem;

  always #5 clock = ~clock;

  jogador_automatico dut (
    .clock(clock), .reset(reset), .habilitar(habilitar), .leds(leds),
    .errar_en(errar_en), .errar_idx(errar_idx), .botoes(botoes),
    .ocupado(ocupado), .fim_jogada(fim_jogada), .erro_leds(erro_leds),
    .estouro(estouro), .db_estado(db_estado), .db_contagem(db_contagem)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // seq/exp_b nibble i (from the right) is entry i
  typedef struct packed {
    logic [3:0]      n_in;
    logic [7:0][3:0] seq;
    logic            e_en;
    logic [4:0]      e_idx;
    logic [4:0]      exp_cnt;
    logic [2:0]      n_exp;
    logic [3:0][3:0] exp_b;
    logic            exp_erro;
  } vec_t;

  vec_t       vecs [6];
  logic [3:0] exp_q [16];
  int         exp_n;

  task automatic wait_press(input string nm);
    int k = 0;
    while (db_estado != 3'd2 && k < 40) begin
      @(negedge clock);
      k++;
    end
    chk({nm, " silence_to_press"}, k, 9);
  endtask

  task automatic check_replay(input string nm);
    for (int j = 0; j < exp_n; j++) begin
      for (int c = 0; c < 4; c++) begin
        chk({nm, " press_botoes"}, botoes, exp_q[j]);
        chk({nm, " press_ocupado"}, ocupado, 1);
        @(negedge clock);
      end
      for (int c = 0; c < 4; c++) begin
        chk({nm, " gap_botoes"}, botoes, 0);
        chk({nm, " gap_ocupado"}, ocupado, 1);
        @(negedge clock);
      end
    end
    chk({nm, " fim_pulse"}, fim_jogada, 1);
    chk({nm, " fim_ocupado"}, ocupado, 0);
    chk({nm, " fim_estado"}, db_estado, 4);
    @(negedge clock);
    chk({nm, " fim_once"}, fim_jogada, 0);
    chk({nm, " cnt_cleared"}, db_contagem, 0);
    chk({nm, " back_captura"}, db_estado, 1);
  endtask

  task automatic run_round(input vec_t v, input string nm);
    errar_en  = v.e_en;
    errar_idx = v.e_idx;
    for (int i = 0; i < int'(v.n_in); i++) begin
      @(negedge clock);
      leds = v.seq[i];
    end
    @(negedge clock);
    chk({nm, " count"}, db_contagem, v.exp_cnt);
    chk({nm, " erro_leds"}, erro_leds, v.exp_erro);
    leds = 4'd0;
    wait_press(nm);
    exp_n = v.n_exp;
    for (int j = 0; j < exp_n; j++) exp_q[j] = v.exp_b[j];
    check_replay(nm);
    errar_en = 1'b0;
  endtask

  initial begin
    vecs[0] = '{n_in: 4'd3, seq: 32'h00000444, e_en: 1'b0, e_idx: 5'd0, exp_cnt: 5'd1,
                n_exp: 3'd1, exp_b: 16'h0004, exp_erro: 1'b0};
    vecs[1] = '{n_in: 4'd6, seq: 32'h00808001, e_en: 1'b0, e_idx: 5'd0, exp_cnt: 5'd3,
                n_exp: 3'd3, exp_b: 16'h0881, exp_erro: 1'b0};
    vecs[2] = '{n_in: 4'd3, seq: 32'h00000402, e_en: 1'b1, e_idx: 5'd1, exp_cnt: 5'd2,
                n_exp: 3'd2, exp_b: 16'h0082, exp_erro: 1'b0};
    vecs[3] = '{n_in: 4'd3, seq: 32'h00000103, e_en: 1'b0, e_idx: 5'd0, exp_cnt: 5'd1,
                n_exp: 3'd1, exp_b: 16'h0001, exp_erro: 1'b1};
    vecs[4] = '{n_in: 4'd2, seq: 32'h00000021, e_en: 1'b0, e_idx: 5'd0, exp_cnt: 5'd1,
                n_exp: 3'd1, exp_b: 16'h0001, exp_erro: 1'b1};
    vecs[5] = '{n_in: 4'd1, seq: 32'h00000008, e_en: 1'b1, e_idx: 5'd0, exp_cnt: 5'd1,
                n_exp: 3'd1, exp_b: 16'h0001, exp_erro: 1'b1};

    reset = 1'b0; habilitar = 1'b0; errar_en = 1'b0; errar_idx = '0; leds = 4'd0;
    repeat (2) @(negedge clock);
    chk("rst botoes", botoes, 0);
    chk("rst ocupado", ocupado, 0);
    chk("rst fim", fim_jogada, 0);
    chk("rst erro", erro_leds, 0);
    chk("rst estouro", estouro, 0);
    chk("rst estado", db_estado, 0);
    chk("rst cnt", db_contagem, 0);
    reset = 1'b1;
    @(negedge clock);
    chk("disabled stays inicial", db_estado, 0);
    habilitar = 1'b1;
    @(negedge clock);
    chk("enter captura", db_estado, 1);
    repeat (20) @(negedge clock);
    chk("idle waits", db_estado, 1);

    for (int v = 0; v < 6; v++) run_round(vecs[v], $sformatf("vec%0d", v));

    // overflow: 17 separated pulses, first 16 kept
    for (int i = 0; i < 17; i++) begin
      @(negedge clock); leds = 4'b0001 << (i % 4);
      @(negedge clock); leds = 4'd0;
    end
    chk("ovf count", db_contagem, 16);
    chk("ovf estouro", estouro, 1);
    wait_press("ovf");
    exp_n = 16;
    for (int j = 0; j < 16; j++) exp_q[j] = 4'b0001 << (j % 4);
    check_replay("ovf");
    chk("ovf sticky", estouro, 1);

    // abort by habilitar during the second press
    @(negedge clock); leds = 4'b0001;
    @(negedge clock); leds = 4'd0;
    @(negedge clock); leds = 4'b0010;
    @(negedge clock); leds = 4'd0;
    wait_press("abort_hab");
    repeat (9) @(negedge clock);
    chk("abort_hab second press", botoes, 4'b0010);
    habilitar = 1'b0;
    @(negedge clock);
    chk("abort_hab botoes", botoes, 0);
    chk("abort_hab estado", db_estado, 0);
    @(negedge clock);
    chk("abort_hab cnt", db_contagem, 0);
    chk("abort_hab flags kept", erro_leds, 1);
    habilitar = 1'b1;
    @(negedge clock);
    chk("abort_hab resume", db_estado, 1);

    // asynchronous reset mid-press
    @(negedge clock); leds = 4'b0100;
    @(negedge clock); leds = 4'd0;
    wait_press("abort_rst");
    @(negedge clock);
    chk("abort_rst pressing", botoes, 4'b0100);
    #2 reset = 1'b0;
    #1;
    chk("abort_rst botoes", botoes, 0);
    chk("abort_rst estado", db_estado, 0);
    chk("abort_rst cnt", db_contagem, 0);
    chk("abort_rst erro", erro_leds, 0);
    chk("abort_rst estouro", estouro, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("after rst captura", db_estado, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jogador_automatico.md
# jogador_automatico

Automatic player for the memory game. Watches the game's `leds` output while a sequence is displayed and records each displayed LED. When the display goes quiet, it replays the recorded sequence on the game's `botoes` input with fixed press and release timing. It sits beside `jogo_desafio_memoria` in system-level benches and FPGA self-test builds, acting as the player end of the LED-display/button protocol.

## Interface
Parameters:
- `MAX_JOGADAS`, default 16: buffer depth, i.e. the maximum number of entries per round.
- `T_SILENCIO`, default 8: number of consecutive cycles with `leds==0` that ends capture.
- `T_PRESS`, default 4: cycles each button is held.
- `T_GAP`, default 4: cycles of `botoes==0` after each press.
- `CW = $clog2(MAX_JOGADAS)+1`: derived counter width, not overridable.

Ports:
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `habilitar`  in  1  enables the player; low forces INICIAL.
- `leds`  in  4  game LED output; one-hot or zero.
- `errar_en`  in  1  enables injection of one deliberate wrong press.
- `errar_idx`  in  CW  index of the entry to press wrongly.
- `botoes`  out  4  button drive to the game; registered.
- `ocupado`  out  1  high in PRESSIONA and SOLTA.
- `fim_jogada`  out  1  one-cycle pulse after the last release.
- `erro_leds`  out  1  sticky; set when `leds` is non-zero and not one-hot.
- `estouro`  out  1  sticky; set when a capture is attempted while the buffer is full.
- `db_estado`  out  3  state code.
- `db_contagem`  out  CW  number of captured entries.

## Operation
States and codes: INICIAL=0, CAPTURA=1, PRESSIONA=2, SOLTA=3, FIM=4.
- **INICIAL:**
  - `botoes=0`, count=0, index=0.
  - Moves to CAPTURA when `habilitar=1`.
- **CAPTURA:**
  - `leds_prev` is `leds` registered every cycle.
  - A capture event is `leds` one-hot while `leds_prev==0`.
  - On a capture event, write `leds` to `buf[count]` and increment count.
  - A non-zero, non-one-hot `leds` value is never captured and sets `erro_leds`.
  - If a capture event occurs with count==MAX_JOGADAS, set `estouro`; count and buffer are unchanged.
  - Silence counter: cleared whenever `leds!=0`; otherwise increments while count>0 and saturates at `T_SILENCIO`.
  - When silence reaches `T_SILENCIO`, go to PRESSIONA with index=0.
  - With count==0 the silence counter stays 0, so CAPTURA waits indefinitely.
- **PRESSIONA:**
  - `botoes=buf[index]` for `T_PRESS` cycles.
  - If `errar_en=1` and index==`errar_idx`, drive `buf[index]` rotated left by 1 instead (0001→0010, 1000→0001).
  - Then go to SOLTA.
- **SOLTA:**
  - `botoes=0` for `T_GAP` cycles.
  - Then, if index+1<count: index increments and the block returns to PRESSIONA.
  - Otherwise go to FIM.
- **FIM:**
  - `fim_jogada=1` for one cycle; count and silence counter cleared.
  - Next state is CAPTURA. Each game round redisplays the sequence from the start, so the buffer refills.
- `leds` is ignored in PRESSIONA, SOLTA and FIM; `leds_prev` keeps updating.
- `habilitar=0` in any state: the next state is INICIAL and `botoes=0` on the following edge; flags are kept.
- `erro_leds` and `estouro` clear only on `reset`.

## Timing
- **Reset values:**
  - `reset=0` forces state INICIAL immediately (asynchronous).
  - `botoes=0`, `ocupado=0`, `fim_jogada=0`, `erro_leds=0`, `estouro=0`, `db_estado=0`, `db_contagem=0`, `leds_prev=0`.
- **Capture:** `db_contagem` increments on the edge that samples the rising event, one cycle after `leds` changes.
- **Silence to first press:**
  - The last edge with `leds!=0` is followed by `T_SILENCIO` zero-sampled edges.
  - The state is PRESSIONA after the next edge, and `botoes` is valid in that same cycle (registered output).
- **Replay length:**
  - Each entry takes exactly `T_PRESS+T_GAP` cycles.
  - `fim_jogada` is high in the cycle after the last SOLTA cycle.
  - Total from the first PRESSIONA cycle to `fim_jogada`: count·(`T_PRESS+T_GAP`) cycles.
- **Held LED:** a LED held high for several cycles is captured once. The same LED shown twice with a zero gap of at least 1 cycle is captured twice.
- **Direct LED-to-LED change:** a change such as 0001→0010 with no zero cycle between them is not a capture event.
- **Async reset mid-replay:** `botoes` goes to 0 within the same cycle.

## Test plan
- **Single entry:**
  - Stimulus: `leds`=0100 for 3 cycles, then 0.
  - Response: `db_contagem`=1; after 8 silent cycles `botoes`=0100 for 4 cycles, then 0 for 4; `fim_jogada` pulses once; `db_contagem`=0.
- **Three entries with a repeat:**
  - Stimulus: 0001, 0,0, 1000, 0, 1000, 0.
  - Response: replay 0001, 1000, 1000; `ocupado` high for 24 cycles.
- **Error injection:**
  - Stimulus: `errar_en`=1, `errar_idx`=1, sequence 0010,0100.
  - Response: replay 0010, then 1000.
- **Bad LED pattern:**
  - Stimulus: `leds`=0011.
  - Response: `erro_leds`=1, `db_contagem` unchanged; it stays 1 through subsequent normal rounds.
- **Overflow:**
  - Stimulus: `MAX_JOGADAS`=16, 17 separated pulses.
  - Response: `db_contagem`=16, `estouro`=1, replay of the first 16 only.
- **Abort:**
  - Stimulus: drop `habilitar` during the second press, and separately assert `reset`=0 mid-PRESSIONA.
  - Response: `botoes`=0 (the next edge for `habilitar`, immediately for `reset`), `db_estado`=0; after the abort `db_contagem`=0.
